ram_16k: RTL and testbench



---
 rtl/ram_pkg.sv | 28 ++
 rtl/ram_4k_bank.sv | 48 ++++
 rtl/ram_16k.sv | 77 +++++++
 tb/tb_ram_16k.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared types and sizing for the 16K x 16 data memory.
//
// Contents:
//   DATA_W      - word width (16)
//   ADDR_W      - full word-address width (14, 16384 words)
//   BANK_ADDR_W - address width inside one 4K bank (12)
//   NUM_BANKS   - number of 4K banks making up the 16K space (4)
//   BANK_DEPTH  - words per bank
//   word_t      - one memory word
//   addr_t      - full memory address
package ram_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 14;
  localparam int BANK_ADDR_W = 12;
  localparam int NUM_BANKS   = 4;
  localparam int BANK_DEPTH  = 1 << BANK_ADDR_W;
  localparam int SEL_W       = ADDR_W - BANK_ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Upper address bits pick the bank.
  function automatic logic [SEL_W-1:0] bank_of(input addr_t a);
    return a[ADDR_W-1:BANK_ADDR_W];
  endfunction

endpackage

// File: rtl/ram_4k_bank.sv
// ram_4k_bank: 4096 x 16 memory bank, combinational read, synchronous write.
//
// Ports:
//   clk     - system clock, all state changes on the rising edge
//   rst_n   - synchronous active-low reset; clears every word
//   load    - write enable, sampled on the rising edge
//   address - 12-bit word address for read and write
//   in      - write data
//   out     - contents of the word at address (combinational)
//
// Interface: there is no handshake. A write happens on every rising edge
// where rst_n=1 and load=1; a read is simply the current word at address.
module ram_4k_bank
  import ram_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [BANK_ADDR_W-1:0] address,
  input  logic [DATA_W-1:0]      in,
  output logic [DATA_W-1:0]      out
);

  // Word storage carries no reset; instead each word has a "written since
  // reset" flag. Clearing the flag vector in one cycle is equivalent to
  // clearing every word, and words not written since reset read as zero.
  logic [DATA_W-1:0]     mem [BANK_DEPTH];
  logic [BANK_DEPTH-1:0] vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (load) begin
      vld[address] <= 1'b1;
    end
  end

  // Data array writes are gated by rst_n so a write in the reset cycle is
  // discarded (its flag is also cleared above).
  always_ff @(posedge clk) begin
    if (rst_n && load) begin
      mem[address] <= in;
    end
  end

  assign out = vld[address] ? mem[address] : '0;

endmodule

// File: rtl/ram_16k.sv
// ram_16k: 16K x 16 data memory built from four 4K banks.
//
// Ports:
//   clk     - system clock, all state changes on the rising edge
//   rst_n   - synchronous active-low reset; clears every word
//   load    - write enable, sampled on the rising edge
//   address - 14-bit word address for read and write
//   in      - write data
//   out     - read data for the word at address
//
// Configuration macro RAM16K_REG_OUT_EN:
//   undefined - out is combinational, zero-cycle read latency; a write is
//               visible on out right after the edge that performs it.
//   defined   - out is registered: each rising edge captures the word at
//               address (pre-write contents on a same-address write),
//               giving one cycle of read latency; reset clears it to zero.
//
// Interface: there is no handshake. A write happens on every rising edge
// where rst_n=1 and load=1.
module ram_16k
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out
);

  logic [SEL_W-1:0]       bank_sel;
  logic [BANK_ADDR_W-1:0] bank_addr;
  logic [NUM_BANKS-1:0]   bank_load;
  logic [DATA_W-1:0]      bank_out [NUM_BANKS];
  logic [DATA_W-1:0]      rd_word;

  assign bank_sel  = bank_of(address);
  assign bank_addr = address[BANK_ADDR_W-1:0];

  // Only the addressed bank sees load, so exactly one word changes.
  always_comb begin
    bank_load           = '0;
    bank_load[bank_sel] = load;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ram_4k_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (bank_load[b]),
      .address (bank_addr),
      .in      (in),
      .out     (bank_out[b])
    );
  end

  assign rd_word = bank_out[bank_sel];

`ifdef RAM16K_REG_OUT_EN
  logic [DATA_W-1:0] out_q;

  // Banks update with non-blocking writes, so rd_word here is still the
  // pre-write contents when a write hits the same address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= rd_word;
    end
  end

  assign out = out_q;
`else
  assign out = rd_word;
`endif

endmodule

// File: tb/tb_ram_16k.sv
// tb_ram_16k: self-checking bench for ram_16k.
//
// A flat array model of the 16K memory is updated on every rising edge;
// a compare process checks out against it on every falling edge once the
// first reset has happened. Directed tests pin the model with literal
// expectations, then a randomized phase runs against the model.
module tb_ram_16k;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [13:0] address;
  logic [15:0] in;
  logic [15:0] out;

  int checks;
  int errors;

  ram_16k dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .address (address),
    .in      (in),
    .out     (out)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic [15:0] model_mem [16384];
  logic [15:0] model_reg_out;
  bit          model_live;
  logic [15:0] exp_q [$];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16384; i++) model_mem[i] = 16'h0000;
      model_reg_out = 16'h0000;
      model_live    = 1'b1;
    end else if (model_live) begin
      model_reg_out = model_mem[address];
      if (load) model_mem[address] = in;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (model_live) begin
`ifdef RAM16K_REG_OUT_EN
      exp_q.push_back(model_reg_out);
`else
      exp_q.push_back(model_mem[address]);
`endif
      checks++;
      if (out !== exp_q[0]) begin
        errors++;
        $display("FAIL model_cmp t=%0t addr=%0d got=%h exp=%h",
                 $time, address, out, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic lit_check(input string name, input logic [15:0] exp);
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL %s t=%0t addr=%0d got=%h exp=%h", name, $time, address, out, exp);
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // One edge with load=0 so the registered build has caught up too.
  task automatic rd_check(input string name, input logic [13:0] a, input logic [15:0] exp);
    address = a;
    load    = 1'b0;
    @(posedge clk);
    #2;
    lit_check(name, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [13:0] base;
    model_live = 1'b0;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    load       = 1'b0;
    address    = '0;
    in         = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset then read.
    for (int a = 0; a < 20; a++) rd_check("reset_low", 14'(a), 16'h0000);
    for (int a = 16380; a < 16384; a++) rd_check("reset_high", 14'(a), 16'h0000);

    // Write/readback.
    for (int a = 0; a < 20; a++) wr(14'(a), 16'(a + 1));
    for (int a = 0; a < 20; a++) rd_check("readback", 14'(a), 16'(a + 1));
    rd_check("readback_7", 14'd7, 16'h0008);

    // Hold with load=0.
    in = 16'hFFFF;
    for (int a = 0; a < 20; a++) begin
      address = 14'(a);
      @(posedge clk);
      #1;
    end
    rd_check("hold_3", 14'd3, 16'h0004);
    rd_check("hold_19", 14'd19, 16'h0014);

    // Bank boundaries.
    wr(14'd4095,  16'hA5A5);
    wr(14'd4096,  16'h5A5A);
    wr(14'd12288, 16'h1234);
    wr(14'd16383, 16'hBEEF);
    rd_check("bnd_4095",  14'd4095,  16'hA5A5);
    rd_check("bnd_4096",  14'd4096,  16'h5A5A);
    rd_check("bnd_12288", 14'd12288, 16'h1234);
    rd_check("bnd_16383", 14'd16383, 16'hBEEF);
    rd_check("bnd_4094",  14'd4094,  16'h0000);
    rd_check("bnd_4097",  14'd4097,  16'h0000);
    rd_check("bnd_12287", 14'd12287, 16'h0000);

    // Same-address overwrite and timing.
    wr(14'd10, 16'h1111);
`ifndef RAM16K_REG_OUT_EN
    address = 14'd10;
    in      = 16'h2222;
    load    = 1'b1;
    #2;
    lit_check("ovw_before", 16'h1111);
    @(posedge clk);
    #1;
    load = 1'b0;
    lit_check("ovw_after", 16'h2222);
`else
    wr(14'd10, 16'h2222);
`endif
    rd_check("ovw_final", 14'd10, 16'h2222);

    // Reset priority over load.
    rst_n   = 1'b0;
    load    = 1'b1;
    address = 14'd5;
    in      = 16'h7777;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load  = 1'b0;
    rd_check("rstpri_5",     14'd5,     16'h0000);
    rd_check("rstpri_7",     14'd7,     16'h0000);
    rd_check("rstpri_4096",  14'd4096,  16'h0000);
    rd_check("rstpri_16383", 14'd16383, 16'h0000);

    // Randomized phase, biased toward bank edges so addresses recur.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      load  = $urandom_range(0, 1);
      in    = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 2) == 0) begin
        address = 14'($urandom_range(0, 16383));
      end else begin
        base    = 14'($urandom_range(0, 3) * 4096);
        address = 14'(base + 14'd16380 + 14'($urandom_range(0, 7)));
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    load  = 1'b0;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
